ttl_nand_arbiter: RTL and testbench
===================================

# ttl_nand_arbiter

Round-robin arbiter and sequencer sharing one registered NAND evaluation slot among BLOCKS requesters, each presenting a WIDTH_IN-bit operand group. Requests are captured on rising edges into a sticky pending register. Exactly one requester is served per Clk cycle in fair rotation. The result is returned with a one-hot grant and a valid strobe. The block sits between multiple requesters and one time-multiplexed quad-NAND-style gate function in the chip library.

## Interface
- BLOCKS, 4: number of requesters (2..16).
- WIDTH_IN, 2: operand bits per requester.
- DELAY_RISE, 0: rise delay on all outputs.
- DELAY_FALL, 0: fall delay on all outputs.
- Clk  input  1  clock; all state changes on the rising edge.
- Clear_bar  input  1  reset; asynchronous, active-low.
- Enable_bar  input  1  active-low service enable. When high, grants are frozen and requests are still captured.
- Req  input  BLOCKS  per-requester request lines. A 0→1 transition posts one request.
- A_2D  input  BLOCKS*WIDTH_IN  packed operands. Requester i occupies bits [i*WIDTH_IN +: WIDTH_IN].
- Grant  output  BLOCKS  registered one-hot grant, high for exactly one cycle per service.
- Valid  output  1  registered; high in the same cycle as any Grant bit.
- Y  output  1  registered NAND of the granted operand group; 1 when Valid is low.
- Pending  output  BLOCKS  registered sticky request flags awaiting service.

## Operation
- Reset (Clear_bar low, asynchronous, held): Grant=0, Valid=0, Y=1, Pending=0, Req history=0, last-served pointer=BLOCKS-1, so requester 0 has first priority.
- Edge capture:
  - rise_i = Req[i] & ~Req_prev[i]; Req_prev is updated every Clk edge.
  - A Req held high through reset release counts as a rise on the first edge.
- Pending update per edge: Pending_next = (Pending & ~served) | rise.
  - A rise on the bit being served in the same edge sets it again (set wins).
  - A second rise on an already-pending bit is merged; it is not counted twice.
- Two-state FSM:
  - IDLE: Pending=0 or Enable_bar=1. Outputs Grant=0, Valid=0, Y=1.
  - SERVE: Pending≠0 and Enable_bar=0 at the edge.
    - Winner = first set Pending bit searching from pointer+1 upward, wrapping modulo BLOCKS.
    - Grant=onehot(winner), Valid=1, Y=~&A[winner] sampled at this edge.
    - pointer=winner; the winner's Pending bit clears unless it is re-risen.
  - SERVE→SERVE continues every cycle while Pending stays nonzero. SERVE→IDLE when Pending empties or Enable_bar goes high.
- Requests captured in the same edge as a service do not compete in that edge; the arbiter decides only on the registered Pending.
- Pointer wraps from BLOCKS-1 to 0. The pointer is unchanged in IDLE.
- Enable_bar high: no grant, pointer held, Pending still accumulates. Service resumes on the first edge with Enable_bar low.
- Reset asserted mid-service clears all state immediately, including an in-flight Grant. Served results are never replayed.

## Timing
- Req rise sampled at edge k, so Pending[i]=1 after edge k.
- The earliest grant is at edge k+1: Grant/Valid/Y are valid after edge k+1 for one cycle. Latency is therefore 2 edges when uncontended.
- Operands are sampled at the grant edge, so A_2D must be stable only around that edge. Holding the operand from Req rise until Grant is the requester's rule.
- Worst-case wait with all requesters pending is BLOCKS cycles after the pending edge.
- Throughput: one service per cycle, with no idle bubble between consecutive grants.
- All outputs are driven through #(DELAY_RISE, DELAY_FALL). Zero-delay defaults are cycle-exact.

## Test plan
- Reset: Clear_bar=0 with Req=4'b1111 → Grant=0, Valid=0, Y=1, Pending=0. Release reset → Pending=4'b1111 after the first edge, then Grant 0001, 0010, 0100, 1000 on consecutive cycles, then Valid=0.
- Single request, BLOCKS=4, WIDTH_IN=2: Req[2] rises at edge 1 with A[2]=2'b11 → Grant=4'b0100, Valid=1, Y=0 after edge 2. Repeat with A[2]=2'b10 → Y=1.
- Fairness and wrap: pointer=2 (after serving requester 2), Pending=4'b0101 → grants 0001 is skipped for requester 0? No: search runs 3,0,1,… so Grant=0001 (requester 0) next, then 0100 (requester 2).
- Simultaneous set/clear: Req[1] re-rises on the edge that serves requester 1 → Pending[1] stays 1, and requester 1 is served again on its next round-robin turn.
- Freeze: Enable_bar=1 with Pending=4'b0011 for 3 cycles → Grant=0 and Pending held. Enable_bar=0 → Grant=0001 on the next edge.
- Reset mid-service: Clear_bar pulsed low while Grant=4'b0010 → Grant, Valid and Pending go to 0 immediately and Y=1. After release with Req low, there is no grant.

Source files
------------

// File: rtl/ttl_nand_arbiter.sv
// Round-robin arbiter that time-shares one registered NAND slot among BLOCKS
// requesters; rising Req edges post sticky pending flags served one per cycle.

module ttl_nand_lane #(
  parameter int WIDTH_IN = 2
) (
  input  logic                req,
  input  logic                req_prev,
  input  logic                pending,
  input  logic                served,
  input  logic [WIDTH_IN-1:0] opnd,
  output logic                pending_nxt,
  output logic                nand_y
);
  logic rise;

  always_comb begin
    rise        = req & ~req_prev;
    // a rise on the lane being served re-posts it
    pending_nxt = (pending & ~served) | rise;
    nand_y      = ~&opnd;
  end
endmodule

module ttl_nand_arbiter #(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear_bar,
  input  logic                         Enable_bar,
  input  logic [BLOCKS-1:0]            Req,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Grant,
  output logic                         Valid,
  output logic                         Y,
  output logic [BLOCKS-1:0]            Pending
);
  localparam int PW = $clog2(BLOCKS);

  typedef enum logic {ST_IDLE, ST_SERVE} state_e;

  // Output delays are a library timing annotation; the RTL is cycle-exact.
  if (BLOCKS < 2 || BLOCKS > 16) begin : g_chk_blocks
    $error("BLOCKS out of range");
  end
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_chk_delay
    $error("negative output delay");
  end

  state_e            state_q, state_d;
  logic [BLOCKS-1:0] req_prev_q, pending_q, pending_d, grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d, win_idx;
  logic              y_q, y_d, win_found, serve;
  logic [BLOCKS-1:0] pending_nxt, nand_y;

  for (genvar i = 0; i < BLOCKS; i++) begin : g_lane
    ttl_nand_lane #(.WIDTH_IN(WIDTH_IN)) u_lane (
      .req         (Req[i]),
      .req_prev    (req_prev_q[i]),
      .pending     (pending_q[i]),
      .served      (grant_d[i]),
      .opnd        (A_2D[i*WIDTH_IN +: WIDTH_IN]),
      .pending_nxt (pending_nxt[i]),
      .nand_y      (nand_y[i])
    );
  end

  // Search starts just past the last-served requester and wraps.
  always_comb begin
    int      idx;
    logic [PW-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = 0;
    idx_w     = '0;
    for (int off = 1; off <= BLOCKS; off++) begin
      idx   = (int'(ptr_q) + off) % BLOCKS;
      idx_w = PW'(idx);
      if (!win_found && pending_q[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  always_comb begin
    serve   = win_found & ~Enable_bar;
    grant_d = '0;
    if (serve) grant_d[win_idx] = 1'b1;
    pending_d = pending_nxt;
    y_d       = serve ? nand_y[win_idx] : 1'b1;
    ptr_d     = serve ? win_idx : ptr_q;
    state_d   = serve ? ST_SERVE : ST_IDLE;
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q    <= ST_IDLE;
      req_prev_q <= '0;
      pending_q  <= '0;
      grant_q    <= '0;
      y_q        <= 1'b1;
      ptr_q      <= PW'(BLOCKS - 1);
    end else begin
      state_q    <= state_d;
      req_prev_q <= Req;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      y_q        <= y_d;
      ptr_q      <= ptr_d;
    end
  end

  assign Grant   = grant_q;
  assign Valid   = (state_q == ST_SERVE);
  assign Y       = y_q;
  assign Pending = pending_q;
endmodule

// File: tb/tb_ttl_nand_arbiter.sv
// Directed bench for ttl_nand_arbiter (BLOCKS=4, WIDTH_IN=2).

module tb_ttl_nand_arbiter;
  logic       Clk = 1'b0;
  logic       Clear_bar, Enable_bar;
  logic [3:0] Req;
  logic [7:0] A_2D;
  logic [3:0] Grant, Pending;
  logic       Valid, Y;
  int tests = 0;
  int fails = 0;

  ttl_nand_arbiter #(.BLOCKS(4), .WIDTH_IN(2), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .Clk(Clk), .Clear_bar(Clear_bar), .Enable_bar(Enable_bar), .Req(Req),
    .A_2D(A_2D), .Grant(Grant), .Valid(Valid), .Y(Y), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic v, input logic y,
                         input logic [3:0] p);
    chk({tag, ".grant"},   32'(Grant),   32'(g));
    chk({tag, ".valid"},   32'(Valid),   32'(v));
    chk({tag, ".y"},       32'(Y),       32'(y));
    chk({tag, ".pending"}, 32'(Pending), 32'(p));
  endtask

  initial begin
    Clear_bar = 1'b0; Enable_bar = 1'b0; Req = 4'b1111;
    A_2D = {2'b11, 2'b10, 2'b01, 2'b11};
    tick(); tick();
    chk_out("reset", 4'b0000, 1'b0, 1'b1, 4'b0000);

    // Req held through reset release posts all four on the first edge
    Clear_bar = 1'b1;
    tick(); chk_out("rel_pend", 4'b0000, 1'b0, 1'b1, 4'b1111);
    tick(); chk_out("rr0", 4'b0001, 1'b1, 1'b0, 4'b1110);
    tick(); chk_out("rr1", 4'b0010, 1'b1, 1'b1, 4'b1100);
    tick(); chk_out("rr2", 4'b0100, 1'b1, 1'b1, 4'b1000);
    tick(); chk_out("rr3", 4'b1000, 1'b1, 1'b0, 4'b0000);
    tick(); chk_out("rr_idle", 4'b0000, 1'b0, 1'b1, 4'b0000);
    Req = 4'b0000;
    tick();

    // single request, operand 11 then 10
    Req = 4'b0100; A_2D[5:4] = 2'b11;
    tick(); chk_out("single_pend", 4'b0000, 1'b0, 1'b1, 4'b0100);
    Req = 4'b0000;
    tick(); chk_out("single_g11", 4'b0100, 1'b1, 1'b0, 4'b0000);
    tick(); chk_out("single_idle", 4'b0000, 1'b0, 1'b1, 4'b0000);
    Req = 4'b0100; A_2D[5:4] = 2'b10;
    tick(); Req = 4'b0000;
    tick(); chk_out("single_g10", 4'b0100, 1'b1, 1'b1, 4'b0000);

    // pointer=2, Pending=0101: search 3,0 -> requester 0 first
    Req = 4'b0101;
    tick(); chk_out("fair_pend", 4'b0000, 1'b0, 1'b1, 4'b0101);
    Req = 4'b0000;
    tick(); chk_out("fair_g0", 4'b0001, 1'b1, 1'b0, 4'b0100);
    tick(); chk_out("fair_g2", 4'b0100, 1'b1, 1'b1, 4'b0000);
    tick();

    // requester 1 re-rises on its own service edge
    Req = 4'b0011;
    tick(); chk_out("sc_pend", 4'b0000, 1'b0, 1'b1, 4'b0011);
    Req = 4'b0000;
    tick(); chk_out("sc_g0", 4'b0001, 1'b1, 1'b0, 4'b0010);
    Req = 4'b1010;
    tick(); chk_out("sc_g1", 4'b0010, 1'b1, 1'b1, 4'b1010);
    Req = 4'b0000;
    tick(); chk_out("sc_g3", 4'b1000, 1'b1, 1'b0, 4'b0010);
    tick(); chk_out("sc_g1b", 4'b0010, 1'b1, 1'b1, 4'b0000);
    tick(); chk_out("sc_idle", 4'b0000, 1'b0, 1'b1, 4'b0000);

    // freeze with Pending=0011, pointer=1
    Enable_bar = 1'b1; Req = 4'b0011;
    tick(); Req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_out("freeze", 4'b0000, 1'b0, 1'b1, 4'b0011);
    end
    Enable_bar = 1'b0;
    tick(); chk_out("thaw_g0", 4'b0001, 1'b1, 1'b0, 4'b0010);
    tick(); chk_out("thaw_g1", 4'b0010, 1'b1, 1'b1, 4'b0000);
    tick();

    // reset mid-service while Grant=0010 and Pending[0] set
    Req = 4'b0010;
    tick(); Req = 4'b0001;
    tick(); chk_out("mid_pre", 4'b0010, 1'b1, 1'b1, 4'b0001);
    Req = 4'b0000;
    #2 Clear_bar = 1'b0;
    #1 chk_out("mid_async", 4'b0000, 1'b0, 1'b1, 4'b0000);
    tick();
    Clear_bar = 1'b1;
    tick(); chk_out("mid_post1", 4'b0000, 1'b0, 1'b1, 4'b0000);
    tick(); chk_out("mid_post2", 4'b0000, 1'b0, 1'b1, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
